// File: rtl/hall_commutator.sv
// Six-step BLDC commutator: hall synchroniser/filter, sector decode, dead-time
// insertion and sticky hall-code / stall faults feeding three phase drivers.
module hall_commutator #(
    parameter int DUTY_WIDTH    = 10,
    parameter int FILTER_CYCLES = 16,
    parameter int DEAD_CYCLES   = 32,
    parameter int STALL_WIDTH   = 20
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  direction,
    input  logic                  brake,
    input  logic [DUTY_WIDTH-1:0] duty_cycle,
    input  logic [2:0]            hall,
    output logic [DUTY_WIDTH-1:0] duty_a,
    output logic [DUTY_WIDTH-1:0] duty_b,
    output logic [DUTY_WIDTH-1:0] duty_c,
    output logic                  high_z_a,
    output logic                  high_z_b,
    output logic                  high_z_c,
    output logic                  hall_fault,
    output logic                  stall,
    output logic [2:0]            sector
);

    localparam int FCW = $clog2(FILTER_CYCLES + 1);
    localparam int DCW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [FCW-1:0]         FILTER_DONE = FCW'(FILTER_CYCLES);
    localparam logic [DCW-1:0]         DEAD_LOAD   = DCW'(DEAD_CYCLES - 1);
    localparam logic [STALL_WIDTH-1:0] STALL_LAST  = {{(STALL_WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        IDLE,
        DEAD,
        DRIVE,
        BRAKE,
        FAULT
    } state_t;

    // Returns {valid, sector}; 000 and 111 are not legal hall codes.
    function automatic logic [3:0] decode_hall(input logic [2:0] code);
        case (code)
            3'b101:  return {1'b1, 3'd0};
            3'b100:  return {1'b1, 3'd1};
            3'b110:  return {1'b1, 3'd2};
            3'b010:  return {1'b1, 3'd3};
            3'b011:  return {1'b1, 3'd4};
            3'b001:  return {1'b1, 3'd5};
            default: return {1'b0, 3'd0};
        endcase
    endfunction

    logic [2:0]     hall_s1, hall_s2, hall_last, hall_filt;
    logic [FCW-1:0] stab_cnt, stab_next;
    logic           filter_valid, filt_update;
    logic [3:0]     new_code, cur_code;
    logic           code_valid, hall_bad;

    always_comb begin
        if (hall_s2 != hall_last) begin
            stab_next = FCW'(1);
        end else if (stab_cnt < FILTER_DONE) begin
            stab_next = stab_cnt + 1'b1;
        end else begin
            stab_next = stab_cnt;
        end
        filt_update = (stab_next == FILTER_DONE) && (!filter_valid || (hall_s2 != hall_filt));
        new_code    = decode_hall(hall_s2);
        cur_code    = decode_hall(hall_filt);
        code_valid  = cur_code[3];
        hall_bad    = filter_valid && !code_valid;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hall_s1      <= '0;
            hall_s2      <= '0;
            hall_last    <= '0;
            hall_filt    <= '0;
            stab_cnt     <= '0;
            filter_valid <= 1'b0;
            sector       <= '0;
        end else begin
            hall_s1   <= hall;
            hall_s2   <= hall_s1;
            hall_last <= hall_s2;
            stab_cnt  <= stab_next;
            if (filt_update) begin
                hall_filt    <= hall_s2;
                filter_valid <= 1'b1;
                // An invalid code keeps the last good sector on the output.
                if (new_code[3]) begin
                    sector <= new_code[2:0];
                end
            end
        end
    end

    state_t                 state, state_next;
    logic [DCW-1:0]         dead_cnt, dead_next;
    logic [2:0]             drv_sector, drv_sector_next;
    logic                   drv_dir, drv_dir_next;
    logic [STALL_WIDTH-1:0] stall_cnt, stall_cnt_next;
    logic                   stall_expire, set_hall_fault, set_stall, clear_faults;

    always_comb begin
        stall_expire    = (state == DRIVE) && (duty_cycle != '0) && (stall_cnt == STALL_LAST);
        state_next      = state;
        dead_next       = dead_cnt;
        drv_sector_next = drv_sector;
        drv_dir_next    = drv_dir;
        set_hall_fault  = 1'b0;
        set_stall       = 1'b0;
        clear_faults    = 1'b0;

        if (!enable) begin
            state_next   = IDLE;
            clear_faults = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (filter_valid && code_valid) begin
                        state_next = DEAD;
                        dead_next  = DEAD_LOAD;
                    end
                end
                FAULT: state_next = FAULT;
                default: begin
                    if (hall_bad) begin
                        state_next     = FAULT;
                        set_hall_fault = 1'b1;
                    end else if (stall_expire) begin
                        state_next = FAULT;
                        set_stall  = 1'b1;
                    end else if (state == DEAD) begin
                        if (dead_cnt == '0) begin
                            if (brake) begin
                                state_next = BRAKE;
                            end else begin
                                state_next      = DRIVE;
                                drv_sector_next = sector;
                                drv_dir_next    = direction;
                            end
                        end else begin
                            dead_next = dead_cnt - 1'b1;
                        end
                    end else if (state == DRIVE) begin
                        if (brake || (sector != drv_sector) || (direction != drv_dir)) begin
                            state_next = DEAD;
                            dead_next  = DEAD_LOAD;
                        end
                    end else if (!brake) begin
                        state_next = DEAD;
                        dead_next  = DEAD_LOAD;
                    end
                end
            endcase
        end

        if (filt_update || (state_next != DRIVE)) begin
            stall_cnt_next = '0;
        end else if ((state == DRIVE) && (duty_cycle != '0)) begin
            stall_cnt_next = stall_cnt + 1'b1;
        end else begin
            stall_cnt_next = stall_cnt;
        end
    end

    // Outputs are computed from the next state so they change at the same edge.
    logic [1:0]            fwd_hi, fwd_lo, hi_idx, lo_idx;
    logic [DUTY_WIDTH-1:0] duty_n [3];
    logic [2:0]            high_z_n;

    always_comb begin
        case (drv_sector_next)
            3'd0:    begin fwd_hi = 2'd0; fwd_lo = 2'd1; end
            3'd1:    begin fwd_hi = 2'd0; fwd_lo = 2'd2; end
            3'd2:    begin fwd_hi = 2'd1; fwd_lo = 2'd2; end
            3'd3:    begin fwd_hi = 2'd1; fwd_lo = 2'd0; end
            3'd4:    begin fwd_hi = 2'd2; fwd_lo = 2'd0; end
            3'd5:    begin fwd_hi = 2'd2; fwd_lo = 2'd1; end
            default: begin fwd_hi = 2'd0; fwd_lo = 2'd1; end
        endcase
        hi_idx = drv_dir_next ? fwd_lo : fwd_hi;
        lo_idx = drv_dir_next ? fwd_hi : fwd_lo;

        for (int unsigned p = 0; p < 3; p++) begin
            duty_n[p]   = '0;
            high_z_n[p] = 1'b1;
            if (state_next == BRAKE) begin
                high_z_n[p] = 1'b0;
            end else if (state_next == DRIVE) begin
                if (hi_idx == 2'(p)) begin
                    duty_n[p]   = duty_cycle;
                    high_z_n[p] = 1'b0;
                end else if (lo_idx == 2'(p)) begin
                    high_z_n[p] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dead_cnt   <= '0;
            drv_sector <= '0;
            drv_dir    <= 1'b0;
            stall_cnt  <= '0;
            hall_fault <= 1'b0;
            stall      <= 1'b0;
            duty_a     <= '0;
            duty_b     <= '0;
            duty_c     <= '0;
            high_z_a   <= 1'b1;
            high_z_b   <= 1'b1;
            high_z_c   <= 1'b1;
        end else begin
            state      <= state_next;
            dead_cnt   <= dead_next;
            drv_sector <= drv_sector_next;
            drv_dir    <= drv_dir_next;
            stall_cnt  <= stall_cnt_next;
            if (clear_faults) begin
                hall_fault <= 1'b0;
                stall      <= 1'b0;
            end else begin
                if (set_hall_fault) hall_fault <= 1'b1;
                if (set_stall)      stall      <= 1'b1;
            end
            duty_a   <= duty_n[0];
            duty_b   <= duty_n[1];
            duty_c   <= duty_n[2];
            high_z_a <= high_z_n[0];
            high_z_b <= high_z_n[1];
            high_z_c <= high_z_n[2];
        end
    end

endmodule

// File: tb/tb_hall_commutator.sv
// Directed bench for hall_commutator: expected outputs are queued as stimulus
// is applied and popped at the cycle the DUT should present them.
module tb_hall_commutator;

    logic       clock = 1'b0;
    logic       reset, enable, direction, brake;
    logic [9:0] duty_cycle;
    logic [2:0] hall;

    logic [9:0] m_da, m_db, m_dc, s_da, s_db, s_dc;
    logic       m_za, m_zb, m_zc, m_hf, m_st;
    logic       s_za, s_zb, s_zc, s_hf, s_st;
    logic [2:0] m_sec, s_sec;

    always #5 clock = ~clock;

    hall_commutator dut (
        .clock(clock), .reset(reset), .enable(enable), .direction(direction),
        .brake(brake), .duty_cycle(duty_cycle), .hall(hall),
        .duty_a(m_da), .duty_b(m_db), .duty_c(m_dc),
        .high_z_a(m_za), .high_z_b(m_zb), .high_z_c(m_zc),
        .hall_fault(m_hf), .stall(m_st), .sector(m_sec)
    );

    hall_commutator #(.STALL_WIDTH(4)) dut_st (
        .clock(clock), .reset(reset), .enable(enable), .direction(direction),
        .brake(brake), .duty_cycle(duty_cycle), .hall(hall),
        .duty_a(s_da), .duty_b(s_db), .duty_c(s_dc),
        .high_z_a(s_za), .high_z_b(s_zb), .high_z_c(s_zc),
        .hall_fault(s_hf), .stall(s_st), .sector(s_sec)
    );

    typedef struct packed {
        logic [9:0] da, db, dc;
        logic       za, zb, zc, hf, st;
        logic [2:0] sec;
    } outs_t;

    typedef struct {
        string tag;
        bit    sel;
        outs_t val;
    } sb_t;

    sb_t sb[$];
    int  tests_run = 0;
    int  fails     = 0;

    function automatic outs_t obs_main();
        return '{m_da, m_db, m_dc, m_za, m_zb, m_zc, m_hf, m_st, m_sec};
    endfunction

    function automatic outs_t obs_st();
        return '{s_da, s_db, s_dc, s_za, s_zb, s_zc, s_hf, s_st, s_sec};
    endfunction

    function automatic outs_t flt(input int sec, input bit hf, input bit st);
        return '{10'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, hf, st, 3'(sec)};
    endfunction

    function automatic outs_t brk(input int sec);
        return '{10'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'(sec)};
    endfunction

    // Spec drive table: phase index 0=A, 1=B, 2=C.
    function automatic outs_t drv(input int sec, input bit dir, input logic [9:0] d);
        int hi, lo, t;
        outs_t o;
        case (sec)
            0: begin hi = 0; lo = 1; end
            1: begin hi = 0; lo = 2; end
            2: begin hi = 1; lo = 2; end
            3: begin hi = 1; lo = 0; end
            4: begin hi = 2; lo = 0; end
            default: begin hi = 2; lo = 1; end
        endcase
        if (dir) begin t = hi; hi = lo; lo = t; end
        o.da  = (hi == 0) ? d : 10'd0;
        o.db  = (hi == 1) ? d : 10'd0;
        o.dc  = (hi == 2) ? d : 10'd0;
        o.za  = !(hi == 0 || lo == 0);
        o.zb  = !(hi == 1 || lo == 1);
        o.zc  = !(hi == 2 || lo == 2);
        o.hf  = 1'b0;
        o.st  = 1'b0;
        o.sec = 3'(sec);
        return o;
    endfunction

    task automatic expect_out(input string tag, input bit sel, input outs_t v);
        sb.push_back('{tag, sel, v});
    endtask

    task automatic check_next();
        sb_t   e;
        outs_t o;
        tests_run++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            o = e.sel ? obs_st() : obs_main();
            assert (o === e.val) else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        logic [2:0] fwd_codes [6];
        int         fwd_secs  [6];
        logic [2:0] rev_codes [5];
        int         rev_secs  [5];
        fwd_codes = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};
        fwd_secs  = '{1, 2, 3, 4, 5, 0};
        rev_codes = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100};
        rev_secs  = '{5, 4, 3, 2, 1};

        reset = 1'b1; enable = 1'b0; direction = 1'b0; brake = 1'b0;
        duty_cycle = 10'd300; hall = 3'b101;
        #3;
        expect_out("reset", 0, flt(0, 0, 0)); check_next();
        #9;
        reset = 1'b0; enable = 1'b1;

        expect_out("filter_accept_idle", 0, flt(0, 0, 0)); tick(18); check_next();
        expect_out("dead_entry", 0, flt(0, 0, 0));          tick(1);  check_next();
        expect_out("dead_last", 0, flt(0, 0, 0));           tick(31); check_next();
        expect_out("first_drive", 0, drv(0, 0, 300));
        expect_out("st_first_drive", 1, drv(0, 0, 300));
        tick(1); check_next(); check_next();

        expect_out("st_before_timeout", 1, drv(0, 0, 300)); tick(14); check_next();
        expect_out("st_timeout", 1, flt(0, 0, 1));          tick(1);  check_next();

        enable = 1'b0;
        expect_out("enable_low", 0, flt(0, 0, 0));
        expect_out("st_enable_low_clear", 1, flt(0, 0, 0));
        tick(1); check_next(); check_next();

        enable = 1'b1; duty_cycle = 10'd0;
        expect_out("dead_exact", 0, flt(0, 0, 0)); tick(32); check_next();
        expect_out("drive_duty0", 0, drv(0, 0, 0)); tick(1); check_next();
        expect_out("st_no_stall_duty0", 1, drv(0, 0, 0)); tick(20); check_next();

        duty_cycle = 10'd300;
        expect_out("duty_update", 0, drv(0, 0, 300)); tick(1); check_next();

        hall = 3'b100; tick(10); hall = 3'b101;
        expect_out("glitch", 0, drv(0, 0, 300)); tick(25); check_next();

        for (int i = 0; i < 6; i++) begin
            hall = fwd_codes[i];
            expect_out($sformatf("fwd_float%0d", i), 0, flt(fwd_secs[i], 0, 0));
            tick(19); check_next();
            expect_out($sformatf("fwd_drive%0d", i), 0, drv(fwd_secs[i], 0, 300));
            tick(32); check_next();
        end

        direction = 1'b1;
        expect_out("dir_float", 0, flt(0, 0, 0));      tick(1);  check_next();
        expect_out("dir_dead_end", 0, flt(0, 0, 0));   tick(31); check_next();
        expect_out("rev_drive0", 0, drv(0, 1, 300));   tick(1);  check_next();

        for (int i = 0; i < 5; i++) begin
            hall = rev_codes[i];
            expect_out($sformatf("rev_float%0d", i), 0, flt(rev_secs[i], 0, 0));
            tick(19); check_next();
            expect_out($sformatf("rev_drive%0d", i), 0, drv(rev_secs[i], 1, 300));
            tick(32); check_next();
        end

        brake = 1'b1;
        expect_out("brake_float", 0, flt(1, 0, 0));    tick(1);  check_next();
        expect_out("brake_dead_end", 0, flt(1, 0, 0)); tick(31); check_next();
        expect_out("brake_on", 0, brk(1));             tick(1);  check_next();
        brake = 1'b0;
        expect_out("brake_release", 0, flt(1, 0, 0)); tick(1); check_next();
        tick(5);
        reset = 1'b1;
        expect_out("reset_mid_dead", 0, flt(0, 0, 0)); #2; check_next();

        @(posedge clock); #1;
        reset = 1'b0; enable = 1'b1; direction = 1'b0; hall = 3'b100;
        expect_out("restart_drive1", 0, drv(1, 0, 300)); tick(51); check_next();

        hall = 3'b111;
        expect_out("hall_fault", 0, flt(1, 1, 0)); tick(19); check_next();
        hall = 3'b100;
        expect_out("hall_fault_sticky", 0, flt(1, 1, 0)); tick(25); check_next();
        enable = 1'b0;
        expect_out("hall_fault_clear", 0, flt(1, 0, 0)); tick(1); check_next();
        enable = 1'b1;
        expect_out("recover_dead", 0, flt(1, 0, 0));   tick(1);  check_next();
        expect_out("recover_drive", 0, drv(1, 0, 300)); tick(32); check_next();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/hall_commutator.md
# hall_commutator

Six-step BLDC commutation controller that sits directly upstream of the three per-phase drivers. It synchronises and filters the three hall-sensor inputs and maps the hall sector, direction and brake command to a per-phase duty cycle and high-Z request. It inserts an all-phases-floating dead interval on every change of drive pattern. It latches hall-code and stall faults that float all phases.

## Interface
- DUTY_WIDTH, 10, width of duty command and per-phase duty outputs; must equal the phase drivers' duty width.
- FILTER_CYCLES, 16, consecutive identical synchronised hall samples required to accept a new hall code (≥1).
- DEAD_CYCLES, 32, length of all-phase high-Z interval on drive-pattern change (≥1).
- STALL_WIDTH, 20, stall counter width; timeout = 2^STALL_WIDTH−1 cycles.

- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  drive enable; low forces IDLE and clears faults.
- direction  in  1  0 = forward, 1 = reverse.
- brake  in  1  low-side brake request.
- duty_cycle  in  DUTY_WIDTH  commanded duty for the high-driven phase.
- hall  in  3  raw hall inputs {C,B,A}, asynchronous.
- duty_a / duty_b / duty_c  out  DUTY_WIDTH each  per-phase duty to phase drivers.
- high_z_a / high_z_b / high_z_c  out  1 each  per-phase float request.
- hall_fault  out  1  sticky: filtered hall code 000 or 111.
- stall  out  1  sticky: no hall transition within timeout while driving.
- sector  out  3  current filtered sector 0–5.

## Operation
- Hall path: 2-flop synchroniser → stability counter. The filtered code updates when the synchronised value has been equal for FILTER_CYCLES consecutive cycles. filter_valid is set on the first such acceptance after reset.
- Sector map (hall {C,B,A}): 101→0, 100→1, 110→2, 010→3, 011→4, 001→5; 000 and 111 are invalid.
- Forward drive pattern (high / low / float) per sector:
  - 0: A / B / C
  - 1: A / C / B
  - 2: B / C / A
  - 3: B / A / C
  - 4: C / A / B
  - 5: C / B / A
- Reverse: the high and low roles are swapped, float is unchanged.
- Phase encoding:
  - High phase: duty = duty_cycle, high_z = 0.
  - Low phase: duty = 0, high_z = 0. The phase driver holds it at the low rail.
  - Float phase: duty = 0, high_z = 1.
- States:
  - IDLE: all float. Go to DEAD when enable=1 and filter_valid=1 and the code is valid.
  - DEAD: all float, counter loaded with DEAD_CYCLES. When the counter expires, go to BRAKE if brake=1, else DRIVE latching sector and direction.
  - DRIVE: apply the table. Go to DEAD on change of filtered sector, direction, or brake rising.
  - BRAKE: all three phases duty 0, high_z 0. Go to DEAD on brake falling.
  - FAULT: all float, hall_fault and/or stall held. Go to IDLE only when enable=0.
- Priority each cycle: enable=0 (→IDLE, clear both fault flags) > invalid filtered code while filter_valid (→FAULT, hall_fault=1) from DEAD/DRIVE/BRAKE > stall expiry (→FAULT, stall=1) > brake change > sector/direction change.
- Stall counter:
  - Increments in DRIVE while duty_cycle≠0.
  - Clears on any filtered-code update and on leaving DRIVE.
  - Reaching all-ones triggers the stall fault.
- duty_cycle is resampled every cycle in DRIVE. No latching beyond the output register.

## Timing
- Reset values:
  - duty_a/b/c = 0
  - high_z_a/b/c = 1
  - hall_fault = 0, stall = 0, sector = 0
  - state IDLE, filter_valid = 0
  - synchroniser and filter registers 000, counters 0
- All outputs are registered and reflect the state entered at the same edge.
- Hall pin change (held stable) to all-phase float: FILTER_CYCLES+3 edges, i.e. 19 with defaults.
- Float interval is exactly DEAD_CYCLES cycles. The new pattern appears on the following cycle.
- Direction or brake change to float: 1 edge.
- duty_cycle change to duty output in DRIVE: 1 edge.
- enable fall to all float: 1 edge, from any state.
- Hall glitch shorter than FILTER_CYCLES: no filtered change, no output change.
- Sector change during DEAD: the counter is not restarted. The sector latched at expiry is applied.
- reset mid-operation: outputs take their reset values asynchronously.

## Test plan
- Reset, then hall=101, enable=1, duty=300 → after 19 edges + 32 dead cycles: duty_a=300, duty_b=0, duty_c=0, high_z={A0,B0,C1}, sector=0.
- Forward sweep through 101,100,110,010,011,001 → each step shows 32 cycles all-float then the table row; with direction=1 the high and low phases are swapped per row.
- 10-cycle hall pulse to 100 while driving sector 0 → outputs unchanged, sector stays 0.
- Filtered hall 111 in DRIVE → FAULT, hall_fault=1, all float. Restoring a valid hall keeps the fault; enable low for 1 cycle → IDLE, hall_fault=0.
- STALL_WIDTH=4, duty=100, hall held → after 15 DRIVE cycles stall=1, all float. With duty=0 no stall.
- brake=1 in DRIVE → 32 cycles float, then all duty 0 and high_z 0. Assert reset mid-DEAD → immediate reset values.
